// File: rtl/stop_sequencer_pkg.sv
// Shared state codes, default timing constants and the per-state actuator decode
// for the Category-1 stop sequencer.
package stop_sequencer_pkg;

  localparam int STATE_W                 = 3;
  localparam int DEF_POWERUP_CYCLES      = 100;
  localparam int DEF_BRAKE_SETTLE_CYCLES = 50;
  localparam int DEF_STOP_TIMEOUT_CYCLES = 1000;
  localparam int DEF_CNT_W               = 16;

  typedef enum logic [STATE_W-1:0] {
    S_SAFE     = 3'd0,
    S_POWER_UP = 3'd1,
    S_RELEASE  = 3'd2,
    S_RUN      = 3'd3,
    S_DECEL    = 3'd4,
    S_BRAKE    = 3'd5,
    S_FAULT    = 3'd6
  } state_e;

  typedef struct packed {
    logic stop_cmd;
    logic power_en;
    logic brake_release;
    logic ready;
    logic fault;
  } act_t;

  // Moore decode; brake_release is only ever set together with power_en.
  function automatic act_t decode(state_e s);
    act_t a;
    a = '0;
    case (s)
      S_POWER_UP: a.power_en = 1'b1;
      S_RELEASE:  begin a.power_en = 1'b1; a.brake_release = 1'b1; end
      S_RUN:      begin a.power_en = 1'b1; a.brake_release = 1'b1; a.ready = 1'b1; end
      S_DECEL:    begin a.power_en = 1'b1; a.brake_release = 1'b1; a.stop_cmd = 1'b1; end
      S_BRAKE:    a.power_en = 1'b1;
      S_FAULT:    a.fault = 1'b1;
      default:    a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/stop_sequencer_dwell_timer.sv
// Per-state dwell counter: synchronous clear, saturates at all-ones, and flags
// when the count equals a run-time limit.
module stop_sequencer_dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      count <= '0;
    else if (count != '1)
      count <= count + 1'b1;
  end

  assign done = (count == limit);

endmodule

// File: rtl/stop_sequencer.sv
// Orders the actuator power path around the e-stop shutdown decision:
// decel -> brake -> power off on stop, ack-gated power -> release -> run on restart.
module stop_sequencer
  import stop_sequencer_pkg::*;
#(
  parameter int POWERUP_CYCLES      = DEF_POWERUP_CYCLES,
  parameter int BRAKE_SETTLE_CYCLES = DEF_BRAKE_SETTLE_CYCLES,
  parameter int STOP_TIMEOUT_CYCLES = DEF_STOP_TIMEOUT_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shutdown_req,
  input  logic               ack_pulse,
  input  logic               motion_stopped,
  output logic               stop_cmd,
  output logic               power_en,
  output logic               brake_release,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);

  // Dwell of N exits when the counter reads N-1.
  localparam logic [CNT_W-1:0] PU_LIM = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BS_LIM = CNT_W'(BRAKE_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(STOP_TIMEOUT_CYCLES - 1);

  state_e           state, nxt;
  act_t             act;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] dwell_cnt_unused;
  logic             done;
  logic             clr;

  stop_sequencer_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .limit (limit),
    .count (dwell_cnt_unused),
    .done  (done)
  );

  always_comb begin
    nxt   = state;
    limit = '1;
    case (state)
      S_SAFE:     if (ack_pulse && !shutdown_req) nxt = S_POWER_UP;
      S_POWER_UP: begin
        limit = PU_LIM;
        if (shutdown_req)  nxt = S_SAFE;
        else if (done)     nxt = S_RELEASE;
      end
      S_RELEASE:  begin
        limit = BS_LIM;
        if (shutdown_req)  nxt = S_BRAKE;
        else if (done)     nxt = S_RUN;
      end
      S_RUN:      if (shutdown_req) nxt = S_DECEL;
      S_DECEL:    begin
        // Drive reporting rest beats the timeout on the same cycle.
        limit = TO_LIM;
        if (motion_stopped) nxt = S_BRAKE;
        else if (done)      nxt = S_FAULT;
      end
      S_BRAKE:    begin
        limit = BS_LIM;
        if (done) nxt = S_SAFE;
      end
      S_FAULT:    if (ack_pulse && !shutdown_req) nxt = S_SAFE;
      default:    nxt = S_SAFE;
    endcase
  end

  assign clr = (nxt != state);

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_SAFE;
      act   <= '0;
    end else begin
      state <= nxt;
      act   <= decode(nxt);
    end
  end

  assign stop_cmd      = act.stop_cmd;
  assign power_en      = act.power_en;
  assign brake_release = act.brake_release;
  assign ready         = act.ready;
  assign fault         = act.fault;
  assign state_o       = state;

endmodule

// File: tb/tb_stop_sequencer.sv
// Directed bench for stop_sequencer with short dwell parameters (8/4/20).
module tb_stop_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, shutdown_req, ack_pulse, motion_stopped;
  logic       stop_cmd, power_en, brake_release, ready, fault;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // {state_o, stop_cmd, power_en, brake_release, ready, fault}
  localparam logic [7:0] E_SAFE  = 8'h00;
  localparam logic [7:0] E_PU    = 8'h28;
  localparam logic [7:0] E_REL   = 8'h4C;
  localparam logic [7:0] E_RUN   = 8'h6E;
  localparam logic [7:0] E_DECEL = 8'h9C;
  localparam logic [7:0] E_BRAKE = 8'hA8;
  localparam logic [7:0] E_FAULT = 8'hC1;

  stop_sequencer #(
    .POWERUP_CYCLES      (8),
    .BRAKE_SETTLE_CYCLES (4),
    .STOP_TIMEOUT_CYCLES (20),
    .CNT_W               (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .shutdown_req   (shutdown_req),
    .ack_pulse      (ack_pulse),
    .motion_stopped (motion_stopped),
    .stop_cmd       (stop_cmd),
    .power_en       (power_en),
    .brake_release  (brake_release),
    .ready          (ready),
    .fault          (fault),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {state_o, stop_cmd, power_en, brake_release, ready, fault};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (obs() === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs(), exp);
    end
  endtask

  // Checks exp on n consecutive cycles, stepping after each check.
  task automatic dwell(input string tag, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, exp);
      step();
    end
  endtask

  task automatic bringup(input string tag);
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    dwell({tag, "_pu"}, E_PU, 8);
    dwell({tag, "_rel"}, E_REL, 4);
    check({tag, "_run"}, E_RUN);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      assert (!(brake_release && !power_en)) else begin
        n_err++;
        $error("FAIL inv_brake observed=%0b%0b expected=brake->power", brake_release, power_en);
      end
      n_cmp++;
      assert ($countones({ready, stop_cmd, fault}) <= 1) else begin
        n_err++;
        $error("FAIL inv_excl observed=%03b expected=onehot0", {ready, stop_cmd, fault});
      end
    end
  end

  initial begin
    rst_n = 1'b0; shutdown_req = 1'b0; ack_pulse = 1'b0; motion_stopped = 1'b0;
    step(); step();
    check("reset", E_SAFE);
    chk_en = 1'b1;
    rst_n = 1'b1;
    step();
    check("idle", E_SAFE);

    // Same-cycle shutdown and ack resolves as shutdown.
    shutdown_req = 1'b1; ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0; shutdown_req = 1'b0;
    check("safe_ack_sd", E_SAFE);

    // Power-up sequence; ack ignored in RUN.
    bringup("up1");
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    check("run_ack_ign", E_RUN);

    // Controlled stop with motion_stopped after 6 cycles of DECEL.
    shutdown_req = 1'b1;
    step();
    dwell("decel", E_DECEL, 6);
    check("decel_last", E_DECEL);
    motion_stopped = 1'b1;
    step();
    motion_stopped = 1'b0;
    dwell("brake", E_BRAKE, 4);
    check("stop_done", E_SAFE);
    shutdown_req = 1'b0;

    // Stop timeout into FAULT, then ack handling.
    bringup("up2");
    shutdown_req = 1'b1;
    step();
    dwell("decel_to", E_DECEL, 20);
    check("fault_entry", E_FAULT);
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    check("fault_ack_sd", E_FAULT);
    shutdown_req = 1'b0;
    step();
    check("fault_hold", E_FAULT);
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    check("fault_clear", E_SAFE);

    // Shutdown during POWER_UP cycle 3 drops straight to SAFE.
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    dwell("pu_abort", E_PU, 3);
    shutdown_req = 1'b1;
    step();
    check("pu_abort_safe", E_SAFE);
    shutdown_req = 1'b0;
    dwell("pu_abort_idle", E_SAFE, 3);

    // Shutdown during RELEASE goes through BRAKE.
    ack_pulse = 1'b1;
    step();
    ack_pulse = 1'b0;
    dwell("rel_pu", E_PU, 8);
    check("rel_entry", E_REL);
    shutdown_req = 1'b1;
    step();
    dwell("rel_brake", E_BRAKE, 4);
    check("rel_safe", E_SAFE);
    shutdown_req = 1'b0;

    // motion_stopped on the exact timeout cycle wins.
    bringup("up3");
    shutdown_req = 1'b1;
    step();
    dwell("decel_edge", E_DECEL, 19);
    check("decel_edge_last", E_DECEL);
    motion_stopped = 1'b1;
    step();
    motion_stopped = 1'b0;
    check("edge_brake", E_BRAKE);
    dwell("edge_brake_hold", E_BRAKE, 4);
    check("edge_safe", E_SAFE);
    shutdown_req = 1'b0;

    // Reset mid-DECEL.
    bringup("up4");
    shutdown_req = 1'b1;
    step();
    dwell("decel_rst", E_DECEL, 5);
    rst_n = 1'b0;
    step();
    check("rst_mid_decel", E_SAFE);
    rst_n = 1'b1;
    shutdown_req = 1'b0;
    step();
    check("rst_after", E_SAFE);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
